mem_arbiter: RTL

- Shares the single RAM port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined MIPS core.
- Generates ihit/dhit, which feed the hazard unit's stall/flush logic. A missing ihit stalls the PC and the IF/ID latch.
- Sits between the datapath/caches and the RAM model. One transaction is outstanding at a time.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the bus word, the RAM handshake status and the memory arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the memory arbiter and the RAM model.
// The slave view belongs to the arbiter; the master view drives requests and the RAM side.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      merr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access; data has priority.
// Define ARB_FAIR_EN to let a waiting fetch win after STARVE_LIMIT consecutive data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    arb_state_t state_q, state_d;
    logic       inst_first;

`ifdef ARB_FAIR_EN
    localparam int unsigned CntW =
        ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CntW-1:0] starve_q, starve_d;

    assign inst_first = bus.iREN && (starve_q == CntW'(STARVE_LIMIT));

    // Counts data grants taken while a fetch was already waiting.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!bus.iREN) begin
                starve_d = '0;
            end else if (state_d == DGNT) begin
                starve_d = starve_q + CntW'(1);
            end else if (state_d == IGNT) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^STARVE_LIMIT;
    assign inst_first          = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.merr     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        unique case (state_q)
            IDLE: begin
                if (inst_first) begin
                    state_d = IGNT;
                end else if (bus.dREN || bus.dWEN) begin
                    state_d = DGNT;
                end else if (bus.iREN) begin
                    state_d = IGNT;
                end
            end

            DGNT: begin
                // A dropped request abandons the access silently.
                if (!(bus.dREN || bus.dWEN)) begin
                    state_d = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = !bus.dWEN;
                    if (bus.ramstate == ACCESS) begin
                        bus.dhit  = 1'b1;
                        bus.dload = bus.dWEN ? '0 : bus.ramload;
                        state_d   = IDLE;
                    end else if (bus.ramstate == ERROR) begin
                        bus.dhit = 1'b1;
                        bus.merr = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            IGNT: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    bus.ramaddr = bus.iaddr;
                    bus.ramREN  = 1'b1;
                    if (bus.ramstate == ACCESS) begin
                        bus.ihit  = 1'b1;
                        bus.iload = bus.ramload;
                        state_d   = IDLE;
                    end else if (bus.ramstate == ERROR) begin
                        bus.ihit = 1'b1;
                        bus.merr = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
